// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: arms on a PC trigger, then records {pc, alu_result} per commit
// into a circular FIFO that a reader drains over a first-word-fall-through valid/ready port.
module trace_capture_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_out,
    input  logic [XLEN-1:0] alu_result,
    input  logic            commit_valid,
    input  logic            arm,
    input  logic            trig_en,
    input  logic [XLEN-1:0] trig_pc,
    input  logic            stop_on_full,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_pc,
    output logic [XLEN-1:0] rd_alu,
    output logic [AW:0]     count,
    output logic [1:0]      state,
    output logic            overflow
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FROZEN} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q;
    logic [2*XLEN-1:0] mem [DEPTH];
    logic              trig_hit, push_req, full, push, pop, drop;

    // arm wins over a trigger arriving in the same cycle
    assign trig_hit = state_q == ARMED && commit_valid && !arm && (!trig_en || pc_out == trig_pc);
    assign push_req = commit_valid && (state_q == CAPTURE || trig_hit);
    assign full     = count_q == (AW+1)'(DEPTH);
    assign pop      = count_q != '0 && rd_ready;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_q + AW'(push);
            rd_ptr_q   <= rd_ptr_q + AW'(pop);
            count_q    <= count_d;
            overflow_q <= arm ? 1'b0 : (overflow_q || drop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {pc_out, alu_result};
    end

    always_comb begin
        state_d = state_q;
        if (arm)
            state_d = ARMED;
        else if (state_q == CAPTURE || trig_hit)
            state_d = (push && stop_on_full && count_d == (AW+1)'(DEPTH)) ? FROZEN : CAPTURE;
    end

    always_comb begin
        state    = state_q;
        rd_valid = count_q != '0;
        count    = count_q;
        overflow = overflow_q;
        {rd_pc, rd_alu} = mem[rd_ptr_q];
    end
endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb_trace_capture_buffer: scenario tasks drive the trace buffer; a queue scoreboard holds
// the records expected on the read port in order.
module tb_trace_capture_buffer;
    logic        clk = 1'b0;
    logic        reset, commit_valid, arm, trig_en, stop_on_full, rd_ready;
    logic [31:0] pc_out, alu_result, trig_pc;
    logic        rd_valid, overflow;
    logic [31:0] rd_pc, rd_alu;
    logic [4:0]  count;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb [$];

    trace_capture_buffer #(.XLEN(32), .DEPTH(16), .AW(4)) dut (
        .clk(clk), .reset(reset), .pc_out(pc_out), .alu_result(alu_result),
        .commit_valid(commit_valid), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .stop_on_full(stop_on_full), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_pc(rd_pc), .rd_alu(rd_alu), .count(count), .state(state), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_of(input logic [31:0] pc);
        return pc * 3 + 32'h1000_0001;
    endfunction

    // apply one cycle of inputs, then settle 1 time unit past the edge
    task automatic cyc(input logic cv, input logic [31:0] pc, input logic rr);
        commit_valid = cv;
        pc_out       = pc;
        alu_result   = alu_of(pc);
        rd_ready     = rr;
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
        rd_ready     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);
        arm = 1'b0;
    endtask

    task automatic drain(input string name);
        logic [63:0] exp;
        for (int i = 0; i < 40 && rd_valid; i++) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s extra record got pc=%h alu=%h required none", name, rd_pc, rd_alu);
            end else begin
                exp = sb.pop_front();
                if ({rd_pc, rd_alu} !== exp) begin
                    errors++;
                    $display("FAIL %s record got %h required %h", name, {rd_pc, rd_alu}, exp);
                end
            end
            cyc(1'b0, 32'h0, 1'b1);
        end
        checks++;
        if (sb.size() != 0 || rd_valid !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL %s drain end got left=%0d rd_valid=%b count=%0d required 0/0/0", name, sb.size(), rd_valid, count);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rd_valid, count, state, overflow} !== 9'b0) begin
            errors++;
            $display("FAIL reset got rd_valid=%b count=%0d state=%0d ovf=%b required 0/0/0/0", rd_valid, count, state, overflow);
        end
    endtask

    task automatic test_reset_mid_capture();
        do_reset();
        trig_en = 1'b0; stop_on_full = 1'b0;
        pulse_arm();
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h40 + 32'(i) * 4, 1'b0);
        checks++;
        if (count !== 5'd5 || state !== 2'd2) begin
            errors++;
            $display("FAIL mid_capture got count=%0d state=%0d required 5/2", count, state);
        end
        reset = 1'b1;
        cyc(1'b1, 32'h80, 1'b0);
        reset = 1'b0;
        checks++;
        if ({rd_valid, count, state, overflow} !== 9'b0) begin
            errors++;
            $display("FAIL reset_mid got rd_valid=%b count=%0d state=%0d ovf=%b required 0/0/0/0", rd_valid, count, state, overflow);
        end
    endtask

    task automatic test_trigger();
        int peak = 0;
        do_reset();
        trig_en = 1'b1; trig_pc = 32'h10; stop_on_full = 1'b0;
        pulse_arm();
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL trig_armed got state=%0d required 1", state);
        end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] pc = 32'(i) * 4;
            if (pc >= 32'h10) sb.push_back({pc, alu_of(pc)});
            cyc(1'b1, pc, 1'b0);
            if (int'(count) > peak) peak = int'(count);
        end
        checks++;
        if (peak != 4 || state !== 2'd2) begin
            errors++;
            $display("FAIL trig_peak got peak=%0d state=%0d required 4/2", peak, state);
        end
        drain("trig_data");
    endtask

    task automatic test_stop_on_full();
        do_reset();
        trig_en = 1'b0; stop_on_full = 1'b1;
        pulse_arm();
        for (int i = 0; i < 20; i++) begin
            logic [31:0] pc = 32'h100 + 32'(i) * 4;
            if (i < 16) sb.push_back({pc, alu_of(pc)});
            cyc(1'b1, pc, 1'b0);
        end
        checks++;
        if (count !== 5'd16 || state !== 2'd3 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL freeze got count=%0d state=%0d ovf=%b required 16/3/0", count, state, overflow);
        end
        drain("freeze_data");
    endtask

    task automatic test_overflow();
        do_reset();
        trig_en = 1'b0; stop_on_full = 1'b0;
        pulse_arm();
        for (int i = 0; i < 18; i++) begin
            logic [31:0] pc = 32'h200 + 32'(i) * 4;
            if (i < 16) sb.push_back({pc, alu_of(pc)});
            cyc(1'b1, pc, 1'b0);
        end
        checks++;
        if (count !== 5'd16 || overflow !== 1'b1 || state !== 2'd2) begin
            errors++;
            $display("FAIL overflow got count=%0d ovf=%b state=%0d required 16/1/2", count, overflow, state);
        end
        pulse_arm();
        checks++;
        if (overflow !== 1'b0 || state !== 2'd1 || count !== 5'd16) begin
            errors++;
            $display("FAIL rearm got ovf=%b state=%0d count=%0d required 0/1/16", overflow, state, count);
        end
        drain("overflow_data");
    endtask

    task automatic test_full_push_pop();
        logic [63:0] exp;
        do_reset();
        trig_en = 1'b0; stop_on_full = 1'b0;
        pulse_arm();
        for (int i = 0; i < 16; i++) begin
            sb.push_back({32'h300 + 32'(i) * 4, alu_of(32'h300 + 32'(i) * 4)});
            cyc(1'b1, 32'h300 + 32'(i) * 4, 1'b0);
        end
        exp = sb.pop_front();
        checks++;
        if ({rd_pc, rd_alu} !== exp) begin
            errors++;
            $display("FAIL full_pop_head got %h required %h", {rd_pc, rd_alu}, exp);
        end
        sb.push_back({32'h3F0, alu_of(32'h3F0)});
        cyc(1'b1, 32'h3F0, 1'b1);
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop got count=%0d ovf=%b required 16/0", count, overflow);
        end
        drain("full_pp_data");
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        do_reset();
        trig_en = 1'b0; stop_on_full = 1'b0;
        pulse_arm();
        sb.push_back({32'h500, alu_of(32'h500)});
        cyc(1'b1, 32'h500, 1'b1);
        checks++;
        if (count !== 5'd1 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL empty_push_pop got count=%0d rd_valid=%b required 1/1", count, rd_valid);
        end
        for (int i = 1; i <= 40; i++) begin
            logic [31:0] pc = 32'h500 + 32'(i) * 4;
            exp = sb.pop_front();
            checks++;
            if ({rd_pc, rd_alu} !== exp) begin
                errors++;
                $display("FAIL b2b_data[%0d] got %h required %h", i, {rd_pc, rd_alu}, exp);
            end
            sb.push_back({pc, alu_of(pc)});
            cyc(1'b1, pc, 1'b1);
        end
        checks++;
        if (count !== 5'd1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count got count=%0d ovf=%b required 1/0", count, overflow);
        end
        drain("b2b_tail");
    endtask

    initial begin
        reset = 1'b1; commit_valid = 1'b0; arm = 1'b0; trig_en = 1'b0; stop_on_full = 1'b0;
        rd_ready = 1'b0; pc_out = '0; alu_result = '0; trig_pc = '0;
        #1;
        test_reset();
        test_reset_mid_capture();
        test_trigger();
        test_stop_on_full();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
